cache_fill_fsm: RTL and testbench

- Parametrised block-fill controller for the direct-mapped caches that sit between the core and the multi-cycle main memory.
- On a miss it does three things:
  - fetches one whole cache block from memory as a stream of pipelined word reads;
  - writes each returned word into the cache data array;
  - writes the tag when the last word lands.
- It generalises the single-cycle, always-ready memory access of the first-generation core to a memory with arbitrary latency and back-pressure.
- One instance serves the I-cache and one serves the D-cache.

---
 rtl/cache_pkg.sv | 10 +
 rtl/cache_fill_fsm_word_counter.sv | 19 +
 rtl/cache_fill_fsm.sv | 70 +++++++
 tb/tb_cache_fill_fsm.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared state type, default geometry and index-width helper for the block-fill controller
package cache_pkg;
  typedef enum logic {IDLE, FILL} state_e;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_WORDS  = 8;
  function automatic int idx_w(input int words);
    return $clog2(words);
  endfunction
endpackage

// File: rtl/cache_fill_fsm_word_counter.sv
// word_counter: W-bit up counter with synchronous clear (priority) and increment enable
module word_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  // clear wins over increment
  always_comb cnt_d = clr ? '0 : inc ? cnt_q + 1'b1 : cnt_q;
  // count register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: fetches one cache block as pipelined word reads, writes each word, then the tag
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WORDS  = DEF_WORDS,
  localparam int IDX_W = idx_w(WORDS),
  localparam int OFF_W = IDX_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  output logic              fsm_busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_data_valid,
  input  logic [DATA_W-1:0] mem_data,
  output logic              write_data_array,
  output logic [IDX_W-1:0]  data_word_idx,
  output logic [DATA_W-1:0] data_out,
  output logic              write_tag_array,
  output logic              fill_done
);
  localparam int CW = IDX_W + 1;
  localparam logic [CW-1:0] FULL = CW'(WORDS);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              fill_done_q, fill_done_d;
  logic [CW-1:0]     iss_cnt, ret_cnt;
  logic              filling, start, issue, last;
  // next-state and output decode from registered state and counters only
  always_comb begin
    filling          = state_q == FILL;
    start            = !filling && miss_detected;
    mem_req          = filling && (iss_cnt < FULL);
    issue            = mem_req && mem_ready;
    write_data_array = filling && mem_data_valid;
    last             = write_data_array && (ret_cnt == LAST);
    write_tag_array  = last;
    state_d          = start ? FILL : last ? IDLE : state_q;
    base_d           = start ? {miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : base_q;
    fill_done_d      = last;
    fsm_busy         = filling;
    mem_addr         = base_q + ADDR_W'({iss_cnt, 1'b0});
    data_word_idx    = ret_cnt[IDX_W-1:0];
    data_out         = mem_data;
    fill_done        = fill_done_q;
  end
  // FSM state, latched block base and the one-cycle completion pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      fill_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      fill_done_q <= fill_done_d;
    end
  word_counter #(.W(CW)) u_iss (
    .clk(clk), .rst_n(rst_n), .clr(start), .inc(issue), .cnt(iss_cnt)
  );
  word_counter #(.W(CW)) u_ret (
    .clk(clk), .rst_n(rst_n), .clr(start), .inc(write_data_array), .cnt(ret_cnt)
  );
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: directed fill scenarios with a latency-4 memory model and a write/address scoreboard
module tb_cache_fill_fsm;
  typedef struct packed {
    logic [2:0]  idx;
    logic [15:0] data;
    logic        tag;
  } wr_t;

  logic        clk, rst_n;
  logic        miss[3], m_req[3], m_rdy[3], m_vld[3], spur[3];
  logic        busy[3], wr[3], tag[3], done[3];
  logic [15:0] maddr[3], m_addr[3], m_dat[3], dout[3];
  logic [2:0]  idx8;
  logic [0:0]  idx2;
  logic [3:0]  idx16;
  logic        sv[3][4];
  logic [15:0] sa[3][4];
  logic [15:0] addr_q[$];
  wr_t         wr_q[$];
  int          nvec = 0, nerr = 0;

  cache_fill_fsm #(.WORDS(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .miss_detected(miss[0]), .miss_address(maddr[0]),
    .fsm_busy(busy[0]), .mem_req(m_req[0]), .mem_addr(m_addr[0]), .mem_ready(m_rdy[0]),
    .mem_data_valid(m_vld[0]), .mem_data(m_dat[0]), .write_data_array(wr[0]),
    .data_word_idx(idx8), .data_out(dout[0]), .write_tag_array(tag[0]), .fill_done(done[0])
  );
  cache_fill_fsm #(.WORDS(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .miss_detected(miss[1]), .miss_address(maddr[1]),
    .fsm_busy(busy[1]), .mem_req(m_req[1]), .mem_addr(m_addr[1]), .mem_ready(m_rdy[1]),
    .mem_data_valid(m_vld[1]), .mem_data(m_dat[1]), .write_data_array(wr[1]),
    .data_word_idx(idx2), .data_out(dout[1]), .write_tag_array(tag[1]), .fill_done(done[1])
  );
  cache_fill_fsm #(.WORDS(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .miss_detected(miss[2]), .miss_address(maddr[2]),
    .fsm_busy(busy[2]), .mem_req(m_req[2]), .mem_addr(m_addr[2]), .mem_ready(m_rdy[2]),
    .mem_data_valid(m_vld[2]), .mem_data(m_dat[2]), .write_data_array(wr[2]),
    .data_word_idx(idx16), .data_out(dout[2]), .write_tag_array(tag[2]), .fill_done(done[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory: an accepted request returns (addr ^ A5A5) four cycles later, in order
  always @(posedge clk or negedge rst_n)
    for (int i = 0; i < 3; i++)
      if (!rst_n) begin
        for (int k = 0; k < 4; k++) begin
          sv[i][k] <= 1'b0;
          sa[i][k] <= '0;
        end
      end else begin
        sv[i][0] <= m_req[i] && m_rdy[i];
        sa[i][0] <= m_addr[i];
        for (int k = 1; k < 4; k++) begin
          sv[i][k] <= sv[i][k-1];
          sa[i][k] <= sa[i][k-1];
        end
      end

  always_comb
    for (int i = 0; i < 3; i++) begin
      m_vld[i] = sv[i][3] | spur[i];
      m_dat[i] = sa[i][3] ^ 16'hA5A5;
    end

  task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", t, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fill(input logic [15:0] b);
    for (int i = 0; i < 8; i++) begin
      addr_q.push_back(b + 16'(2 * i));
      wr_q.push_back('{idx: 3'(i), data: (b + 16'(2 * i)) ^ 16'hA5A5, tag: (i == 7)});
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done[0] && n < 60) begin
      cyc();
      n++;
    end
  endtask

  // scoreboard for the WORDS=8 instance: accepted addresses and data-array writes in order
  always @(negedge clk)
    if (rst_n) begin
      wr_t e;
      if (m_req[0] && m_rdy[0]) begin
        chk("req_expected", 32'(addr_q.size() > 0), 32'd1);
        if (addr_q.size() > 0) chk("sb_addr", 32'(m_addr[0]), 32'(addr_q.pop_front()));
      end
      if (wr[0]) begin
        chk("wr_expected", 32'(wr_q.size() > 0), 32'd1);
        if (wr_q.size() > 0) begin
          e = wr_q.pop_front();
          chk("sb_idx", 32'(idx8), 32'(e.idx));
          chk("sb_data", 32'(dout[0]), 32'(e.data));
          chk("sb_tag", 32'(tag[0]), 32'(e.tag));
        end
      end
      if (tag[0]) chk("tag_with_data", 32'(wr[0]), 32'd1);
    end

  initial begin
    int n, cnt, tags;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      miss[i] = 1'b0; maddr[i] = '0; m_rdy[i] = 1'b1; spur[i] = 1'b0;
    end
    cyc();
    cyc();
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_req", 32'(m_req[0]), 32'd0);
    chk("rst_addr", 32'(m_addr[0]), 32'd0);
    chk("rst_wr", 32'(wr[0]), 32'd0);
    chk("rst_idx", 32'(idx8), 32'd0);
    chk("rst_tag", 32'(tag[0]), 32'd0);
    chk("rst_done", 32'(done[0]), 32'd0);
    chk("rst_dout", 32'(dout[0]), 32'h0000A5A5);
    rst_n = 1'b1;
    cyc();
    // basic fill, a second miss during FILL, and a miss in the fill_done cycle
    cyc();
    miss[0] = 1'b1; maddr[0] = 16'h1234; expect_fill(16'h1230);
    chk("idle_busy", 32'(busy[0]), 32'd0);
    cyc();
    miss[0] = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      if (c == 3) begin miss[0] = 1'b1; maddr[0] = 16'h5000; end
      if (c == 4) miss[0] = 1'b0;
      if (c == 13) begin miss[0] = 1'b1; maddr[0] = 16'h2000; expect_fill(16'h2000); end
      chk("b_busy", 32'(busy[0]), 32'(c <= 12));
      chk("b_req", 32'(m_req[0]), 32'(c <= 8));
      if (c <= 8) chk("b_addr", 32'(m_addr[0]), 32'(16'h1230 + 16'(2 * (c - 1))));
      chk("b_wr", 32'(wr[0]), 32'(c >= 5 && c <= 12));
      chk("b_tag", 32'(tag[0]), 32'(c == 12));
      chk("b_done", 32'(done[0]), 32'(c == 13));
      cyc();
    end
    miss[0] = 1'b0;
    chk("chain_req", 32'(m_req[0]), 32'd1);
    chk("chain_addr", 32'(m_addr[0]), 32'h2000);
    wait_done(n);
    chk("chain_lat", 32'(n), 32'd12);
    cyc();
    // spurious return while idle
    spur[0] = 1'b1;
    #1;
    chk("spur_wr", 32'(wr[0]), 32'd0);
    chk("spur_tag", 32'(tag[0]), 32'd0);
    cyc();
    spur[0] = 1'b0;
    // back-pressure in cycles 3-5
    cyc();
    miss[0] = 1'b1; maddr[0] = 16'h1234; expect_fill(16'h1230);
    cyc();
    miss[0] = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      m_rdy[0] = !(c >= 3 && c <= 5);
      if (c >= 3 && c <= 6) chk("bp_hold", 32'(m_addr[0]), 32'h1234);
      chk("bp_req", 32'(m_req[0]), 32'(c <= 11));
      chk("bp_tag", 32'(tag[0]), 32'(c == 15));
      chk("bp_done", 32'(done[0]), 32'(c == 16));
      cyc();
    end
    m_rdy[0] = 1'b1;
    // block at the top of the address space
    miss[0] = 1'b1; maddr[0] = 16'hFFF6; expect_fill(16'hFFF0);
    cyc();
    miss[0] = 1'b0;
    chk("wrap_base", 32'(m_addr[0]), 32'h0000FFF0);
    wait_done(n);
    chk("wrap_lat", 32'(n), 32'd12);
    cyc();
    // reset after three returned words
    miss[0] = 1'b1; maddr[0] = 16'h3000; expect_fill(16'h3000);
    cyc();
    miss[0] = 1'b0;
    repeat (6) cyc();
    chk("pre_rst_idx", 32'(idx8), 32'd2);
    cyc();
    spur[0] = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy[0]), 32'd0);
    chk("arst_req", 32'(m_req[0]), 32'd0);
    chk("arst_addr", 32'(m_addr[0]), 32'd0);
    chk("arst_wr", 32'(wr[0]), 32'd0);
    chk("arst_idx", 32'(idx8), 32'd0);
    chk("arst_tag", 32'(tag[0]), 32'd0);
    chk("arst_done", 32'(done[0]), 32'd0);
    chk("arst_dout", 32'(dout[0]), 32'h0000A5A5);
    addr_q.delete();
    wr_q.delete();
    cyc();
    spur[0] = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_idle", 32'(busy[0]), 32'd0);
    miss[0] = 1'b1; maddr[0] = 16'h0040; expect_fill(16'h0040);
    cyc();
    miss[0] = 1'b0;
    chk("post_rst_addr", 32'(m_addr[0]), 32'h0040);
    wait_done(n);
    chk("post_rst_lat", 32'(n), 32'd12);
    cyc();
    chk("sb_drain", 32'(addr_q.size() + wr_q.size()), 32'd0);
    // WORDS=2
    miss[1] = 1'b1; maddr[1] = 16'h00FF;
    cyc();
    miss[1] = 1'b0;
    chk("w2_base", 32'(m_addr[1]), 32'h00FC);
    cnt = 0; tags = 0; n = 0;
    while (!done[1] && n < 60) begin
      if (wr[1]) begin
        chk("w2_idx", 32'(idx2), 32'(cnt));
        chk("w2_data", 32'(dout[1]), 32'((16'h00FC + 16'(2 * cnt)) ^ 16'hA5A5));
        cnt++;
      end
      tags += int'(tag[1]);
      cyc();
      n++;
    end
    chk("w2_writes", 32'(cnt), 32'd2);
    chk("w2_tags", 32'(tags), 32'd1);
    chk("w2_lat", 32'(n), 32'd6);
    // WORDS=16
    miss[2] = 1'b1; maddr[2] = 16'h00FF;
    cyc();
    miss[2] = 1'b0;
    chk("w16_base", 32'(m_addr[2]), 32'h00E0);
    cnt = 0; tags = 0; n = 0;
    while (!done[2] && n < 80) begin
      if (wr[2]) begin
        chk("w16_idx", 32'(idx16), 32'(cnt));
        chk("w16_data", 32'(dout[2]), 32'((16'h00E0 + 16'(2 * cnt)) ^ 16'hA5A5));
        cnt++;
      end
      tags += int'(tag[2]);
      cyc();
      n++;
    end
    chk("w16_writes", 32'(cnt), 32'd16);
    chk("w16_tags", 32'(tags), 32'd1);
    chk("w16_lat", 32'(n), 32'd20);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
